// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard: register-file sizing and the
// operand/destination request record used to query the busy banks.
package issue_scoreboard_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int REG_IDX_W    = $clog2(NUM_REGS_DEF);
  localparam int PENDING_W    = 7;

  typedef struct packed {
    logic                 valid;
    logic                 is_f;
    logic [REG_IDX_W-1:0] idx;
  } sb_req_t;

  function automatic sb_req_t mk_req(input logic valid, input logic is_f,
                                     input logic [REG_IDX_W-1:0] idx);
    sb_req_t r;
    r.valid = valid;
    r.is_f  = is_f;
    r.idx   = idx;
    return r;
  endfunction

endpackage

// File: rtl/scoreboard_bank.sv
// One register file's busy vector: a single set port (issue), a single clear
// port (writeback) and three read ports for rs1/rs2/rd hazard queries.
module scoreboard_bank
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter bit HARD_ZERO = 1'b0,
  parameter int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] q_rs1_idx,
  input  logic [IDX_W-1:0] q_rs2_idx,
  input  logic [IDX_W-1:0] q_rd_idx,
  output logic             q_rs1_busy,
  output logic             q_rs2_busy,
  output logic             q_rd_busy,
  output logic             clr_hit
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // NOTE: combinational blocks start from a full default so no path leaves a
  // bit unassigned, which would otherwise infer a latch.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    if (HARD_ZERO) busy_d[0] = 1'b0;
  end

  // NOTE: the busy vector is plain flops rather than a RAM, so it can and must
  // be cleared by reset; sequential state is updated with non-blocking writes.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign q_rs1_busy = busy_q[q_rs1_idx];
  assign q_rs2_busy = busy_q[q_rs2_idx];
  assign q_rd_busy  = busy_q[q_rd_idx];
  assign clr_hit    = busy_q[clr_idx];

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: RAW/WAW/long-unit interlock over integer and
// (when SCOREBOARD_FREG_EN is defined) float register files.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  input  logic [REG_IDX_W-1:0] dec_rs1,
  input  logic [REG_IDX_W-1:0] dec_rs2,
  input  logic [REG_IDX_W-1:0] dec_rd,
  input  logic                 dec_rs1_is_f,
  input  logic                 dec_rs2_is_f,
  input  logic                 dec_rd_is_f,
  input  logic                 dec_uses_rs1,
  input  logic                 dec_uses_rs2,
  input  logic                 dec_writes_rd,
  input  logic                 dec_long,
  output logic                 issue_ready,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 wb_is_f,
  input  logic                 long_done,
  output logic [PENDING_W-1:0] pending,
  output logic                 idle,
  output logic                 wb_err
);

  localparam int IDX_W = $clog2(NUM_REGS);

  sb_req_t rs1_req, rs2_req, rd_req;
  logic x_rs1_busy, x_rs2_busy, x_rd_busy, x_clr_hit;
  logic f_rs1_busy, f_rs2_busy, f_rd_busy, f_clr_hit;
  logic set_x, set_f, clr_x, clr_f;
  logic raw, waw, fire, rd_is_x0;
  logic set_any, clr_valid, wb_bad;

  logic                 long_busy_q, long_busy_d;
  logic [PENDING_W-1:0] pending_q, pending_d;
  logic                 wb_err_q, wb_err_d;

  assign rs1_req = mk_req(dec_uses_rs1, dec_rs1_is_f, dec_rs1);
  assign rs2_req = mk_req(dec_uses_rs2, dec_rs2_is_f, dec_rs2);
  assign rd_req  = mk_req(dec_writes_rd, dec_rd_is_f, dec_rd);

  assign rd_is_x0 = ~rd_req.is_f && (rd_req.idx == '0);

  assign raw = (rs1_req.valid && (rs1_req.is_f ? f_rs1_busy : x_rs1_busy)) ||
               (rs2_req.valid && (rs2_req.is_f ? f_rs2_busy : x_rs2_busy));
  assign waw = rd_req.valid && (rd_req.is_f ? f_rd_busy : x_rd_busy);

  assign issue_ready = ~raw & ~waw & ~(dec_long & long_busy_q);
  assign fire        = dec_valid & issue_ready;

  assign set_x = fire & rd_req.valid & ~rd_req.is_f & ~rd_is_x0;
  assign clr_x = wb_valid & ~wb_is_f;

  scoreboard_bank #(.NUM_REGS(NUM_REGS), .HARD_ZERO(1'b1)) u_bank_x (
    .clk        (clk),
    .rst        (rst),
    .set_en     (set_x),
    .set_idx    (rd_req.idx[IDX_W-1:0]),
    .clr_en     (clr_x),
    .clr_idx    (wb_rd[IDX_W-1:0]),
    .q_rs1_idx  (rs1_req.idx[IDX_W-1:0]),
    .q_rs2_idx  (rs2_req.idx[IDX_W-1:0]),
    .q_rd_idx   (rd_req.idx[IDX_W-1:0]),
    .q_rs1_busy (x_rs1_busy),
    .q_rs2_busy (x_rs2_busy),
    .q_rd_busy  (x_rd_busy),
    .clr_hit    (x_clr_hit)
  );

`ifdef SCOREBOARD_FREG_EN
  assign set_f = fire & rd_req.valid & rd_req.is_f;
  assign clr_f = wb_valid & wb_is_f;

  scoreboard_bank #(.NUM_REGS(NUM_REGS), .HARD_ZERO(1'b0)) u_bank_f (
    .clk        (clk),
    .rst        (rst),
    .set_en     (set_f),
    .set_idx    (rd_req.idx[IDX_W-1:0]),
    .clr_en     (clr_f),
    .clr_idx    (wb_rd[IDX_W-1:0]),
    .q_rs1_idx  (rs1_req.idx[IDX_W-1:0]),
    .q_rs2_idx  (rs2_req.idx[IDX_W-1:0]),
    .q_rd_idx   (rd_req.idx[IDX_W-1:0]),
    .q_rs1_busy (f_rs1_busy),
    .q_rs2_busy (f_rs2_busy),
    .q_rd_busy  (f_rd_busy),
    .clr_hit    (f_clr_hit)
  );
`else
  // Float registers are untracked: float operands never stall, float
  // destinations are never marked busy and float writebacks are dropped.
  assign set_f      = 1'b0;
  assign clr_f      = 1'b0;
  assign f_rs1_busy = 1'b0;
  assign f_rs2_busy = 1'b0;
  assign f_rd_busy  = 1'b0;
  assign f_clr_hit  = 1'b0;
`endif

  assign set_any   = set_x | set_f;
  assign clr_valid = (clr_x & x_clr_hit) | (clr_f & f_clr_hit);
  assign wb_bad    = (clr_x & ~x_clr_hit) | (clr_f & ~f_clr_hit);

  always_comb begin
    pending_d   = pending_q;
    long_busy_d = long_busy_q;
    wb_err_d    = wb_err_q | wb_bad | (long_done & ~long_busy_q);
    if (set_any && !clr_valid)      pending_d = pending_q + 1'b1;
    else if (!set_any && clr_valid) pending_d = pending_q - 1'b1;
    if (long_done)       long_busy_d = 1'b0;
    if (fire && dec_long) long_busy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      long_busy_q <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      long_busy_q <= long_busy_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign pending = pending_q;
  assign idle    = (pending_q == '0) && !long_busy_q;
  assign wb_err  = wb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed vector table, hand-written
// corner sequences and a randomized run against a register-array model.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

`ifdef SCOREBOARD_FREG_EN
  localparam bit FREG = 1'b1;
`else
  localparam bit FREG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid, dec_rs1_is_f, dec_rs2_is_f, dec_rd_is_f;
  logic       dec_uses_rs1, dec_uses_rs2, dec_writes_rd, dec_long;
  logic [4:0] dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic       wb_valid, wb_is_f, long_done;
  logic       issue_ready, idle, wb_err;
  logic [6:0] pending;

  int checks   = 0;
  int failures = 0;

  issue_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .dec_rs1_is_f (dec_rs1_is_f),
    .dec_rs2_is_f (dec_rs2_is_f),
    .dec_rd_is_f  (dec_rd_is_f),
    .dec_uses_rs1 (dec_uses_rs1),
    .dec_uses_rs2 (dec_uses_rs2),
    .dec_writes_rd(dec_writes_rd),
    .dec_long     (dec_long),
    .issue_ready  (issue_ready),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_is_f      (wb_is_f),
    .long_done    (long_done),
    .pending      (pending),
    .idle         (idle),
    .wb_err       (wb_err)
  );

  always #5 clk = ~clk;

  // Reference model: which registers hold an outstanding result.
  bit m_bx[32];
  bit m_bf[32];
  bit m_long;
  bit m_err;

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_bx[i]) + int'(m_bf[i]);
    return n;
  endfunction

  function automatic bit m_busy(int idx, bit is_f);
    if (is_f) return FREG ? m_bf[idx] : 1'b0;
    return (idx != 0) && m_bx[idx];
  endfunction

  function automatic bit m_ready();
    bit stall = 1'b0;
    if (dec_uses_rs1 && m_busy(int'(dec_rs1), dec_rs1_is_f)) stall = 1'b1;
    if (dec_uses_rs2 && m_busy(int'(dec_rs2), dec_rs2_is_f)) stall = 1'b1;
    if (dec_writes_rd && m_busy(int'(dec_rd), dec_rd_is_f)) stall = 1'b1;
    if (dec_long && m_long) stall = 1'b1;
    return !stall;
  endfunction

  function automatic void m_update();
    bit fire;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_bx[i] = 1'b0;
        m_bf[i] = 1'b0;
      end
      m_long = 1'b0;
      m_err  = 1'b0;
      return;
    end
    fire = dec_valid && m_ready();
    if (wb_valid) begin
      if (wb_is_f) begin
        if (FREG) begin
          if (m_bf[wb_rd]) m_bf[wb_rd] = 1'b0;
          else             m_err = 1'b1;
        end
      end else if (wb_rd != 0 && m_bx[wb_rd]) m_bx[wb_rd] = 1'b0;
      else m_err = 1'b1;
    end
    if (long_done) begin
      if (m_long) m_long = 1'b0;
      else        m_err = 1'b1;
    end
    if (fire) begin
      if (dec_writes_rd) begin
        if (dec_rd_is_f) begin
          if (FREG) m_bf[dec_rd] = 1'b1;
        end else if (dec_rd != 0) m_bx[dec_rd] = 1'b1;
      end
      if (dec_long) m_long = 1'b1;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clock_edge();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic clear_inputs();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    dec_rs1_is_f = 0; dec_rs2_is_f = 0; dec_rd_is_f = 0;
    dec_uses_rs1 = 0; dec_uses_rs2 = 0; dec_writes_rd = 0; dec_long = 0;
    wb_valid = 0; wb_rd = 0; wb_is_f = 0; long_done = 0;
  endtask

  task automatic set_dec(input bit dv, input int rs1, input bit rs1f, input bit u1,
                         input int rd, input bit rdf, input bit wr, input bit lng);
    dec_valid = dv; dec_rs1 = 5'(rs1); dec_rs1_is_f = rs1f; dec_uses_rs1 = u1;
    dec_rd = 5'(rd); dec_rd_is_f = rdf; dec_writes_rd = wr; dec_long = lng;
  endtask

  task automatic set_wb(input bit v, input int rd, input bit f, input bit ld);
    wb_valid = v; wb_rd = 5'(rd); wb_is_f = f; long_done = ld;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    clock_edge();
    clock_edge();
    rst = 1'b0;
  endtask

  typedef struct {
    bit dv; int rs1; bit u1; int rd; bit wr; bit lng;
    bit wbv; int wbrd; bit ld;
    bit exp_ready; int exp_pend; bit exp_idle; bit exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit dv, int rs1, bit u1, int rd, bit wr, bit lng,
                             bit wbv, int wbrd, bit ld,
                             bit er, int ep, bit ei, bit ee);
    vec_t r;
    r.dv = dv; r.rs1 = rs1; r.u1 = u1; r.rd = rd; r.wr = wr; r.lng = lng;
    r.wbv = wbv; r.wbrd = wbrd; r.ld = ld;
    r.exp_ready = er; r.exp_pend = ep; r.exp_idle = ei; r.exp_err = ee;
    return r;
  endfunction

  task automatic pick_wb();
    int cand[$];
    wb_valid = 1'b0; wb_rd = 0; wb_is_f = 1'b0;
    if ($urandom_range(0, 1) == 0) return;
    if ($urandom_range(0, 127) == 0) begin
      wb_valid = 1'b1; wb_rd = 5'($urandom_range(0, 7)); wb_is_f = 1'($urandom_range(0, 1));
      return;
    end
    for (int i = 0; i < 8; i++) begin
      if (m_bx[i]) cand.push_back(i);
      if (FREG && m_bf[i]) cand.push_back(i + 32);
    end
    if (cand.size() == 0) return;
    begin
      int pick = cand[$urandom_range(0, cand.size() - 1)];
      wb_valid = 1'b1;
      wb_rd    = 5'(pick % 32);
      wb_is_f  = (pick >= 32);
    end
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // Reset state: nothing busy, any instruction may issue.
    set_dec(1, 5, 0, 1, 5, 0, 1, 1);
    #1;
    check("reset ready", 32'(issue_ready), 32'(1));
    check("reset pending", 32'(pending), 32'(0));
    check("reset idle", 32'(idle), 32'(1));
    check("reset wb_err", 32'(wb_err), 32'(0));
    clear_inputs();
    clock_edge();
    do_reset();

    // Directed table: RAW, WAW/x0, simultaneous fire+wb, long unit, wb error.
    vecs.push_back(v(1, 1, 1, 5, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(v(1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(1, 5, 1, 6, 1, 0, 1, 5, 0, 0, 0, 1, 0));
    vecs.push_back(v(1, 5, 1, 6, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 1, 0, 1, 6, 0, 1, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 7, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 7, 1, 0, 1, 7, 0, 0, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 7, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 9, 1, 0, 1, 7, 0, 1, 1, 0, 0));
    vecs.push_back(v(1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(v(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 3, 1, 1, 0, 0, 0, 1, 2, 0, 0));
    vecs.push_back(v(1, 0, 0, 4, 1, 1, 0, 0, 0, 0, 2, 0, 0));
    vecs.push_back(v(1, 0, 0, 4, 1, 1, 0, 0, 1, 0, 2, 0, 0));
    vecs.push_back(v(1, 0, 0, 4, 1, 1, 0, 0, 0, 1, 3, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 12, 0, 1, 3, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3, 0, 1));

    foreach (vecs[i]) begin
      clear_inputs();
      set_dec(vecs[i].dv, vecs[i].rs1, 0, vecs[i].u1, vecs[i].rd, 0, vecs[i].wr, vecs[i].lng);
      set_wb(vecs[i].wbv, vecs[i].wbrd, 0, vecs[i].ld);
      #1;
      check($sformatf("vec%0d ready", i), 32'(issue_ready), 32'(vecs[i].exp_ready));
      clock_edge();
      check($sformatf("vec%0d pending", i), 32'(pending), 32'(vecs[i].exp_pend));
      check($sformatf("vec%0d idle", i), 32'(idle), 32'(vecs[i].exp_idle));
      check($sformatf("vec%0d wb_err", i), 32'(wb_err), 32'(vecs[i].exp_err));
    end

    // Reset mid-flight (pending=3, long busy, wb_err set) beats fire/wb/long_done.
    clear_inputs();
    rst = 1'b1;
    set_dec(1, 0, 0, 0, 10, 0, 1, 0);
    set_wb(1, 9, 0, 1);
    clock_edge();
    rst = 1'b0;
    clear_inputs();
    check("rst pending", 32'(pending), 32'(0));
    check("rst idle", 32'(idle), 32'(1));
    check("rst wb_err", 32'(wb_err), 32'(0));
    set_dec(1, 4, 0, 1, 3, 0, 1, 1);
    #1;
    check("rst ready", 32'(issue_ready), 32'(1));
    clock_edge();
    do_reset();

    // long_done while the long unit is free is an error.
    set_wb(0, 0, 0, 1);
    clock_edge();
    clear_inputs();
    check("spurious long_done err", 32'(wb_err), 32'(1));
    do_reset();

    // Integer div, then a float long op waits for long_done, issues next cycle.
    set_dec(1, 0, 0, 0, 3, 0, 1, 1);
    clock_edge();
    set_dec(1, 0, 0, 0, 4, 1, 1, 1);
    #1;
    check("fdiv stall", 32'(issue_ready), 32'(0));
    clock_edge();
    set_wb(0, 0, 0, 1);
    #1;
    check("fdiv stall at done", 32'(issue_ready), 32'(0));
    clock_edge();
    set_wb(0, 0, 0, 0);
    #1;
    check("fdiv go", 32'(issue_ready), 32'(1));
    clock_edge();
    clear_inputs();
    check("fdiv pending", 32'(pending), 32'(FREG ? 2 : 1));
    check("fdiv idle", 32'(idle), 32'(0));
    do_reset();

    // flw f2 then fadd f1 <- f2: stalls only when float tracking exists.
    set_dec(1, 0, 0, 0, 2, 1, 1, 0);
    clock_edge();
    set_dec(1, 2, 1, 1, 1, 1, 1, 0);
    #1;
    check("fadd ready", 32'(issue_ready), 32'(FREG ? 0 : 1));
    clock_edge();
    clear_inputs();
    check("fadd pending", 32'(pending), 32'(FREG ? 1 : 0));
    set_wb(1, 2, 1, 0);
    clock_edge();
    clear_inputs();
    check("float wb no err", 32'(wb_err), 32'(0));
    check("float wb pending", 32'(pending), 32'(0));
    do_reset();

    // Randomized traffic over a small register window against the model.
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 99) == 0);
      dec_valid    = ($urandom_range(0, 3) != 0);
      dec_rs1      = 5'($urandom_range(0, 7));
      dec_rs2      = 5'($urandom_range(0, 7));
      dec_rd       = 5'($urandom_range(0, 7));
      dec_rs1_is_f = 1'($urandom_range(0, 1));
      dec_rs2_is_f = 1'($urandom_range(0, 1));
      dec_rd_is_f  = 1'($urandom_range(0, 1));
      dec_uses_rs1 = 1'($urandom_range(0, 1));
      dec_uses_rs2 = 1'($urandom_range(0, 1));
      dec_writes_rd = ($urandom_range(0, 3) != 0);
      dec_long     = ($urandom_range(0, 5) == 0);
      long_done    = m_long ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
      pick_wb();
      #1;
      check($sformatf("rand%0d ready", c), 32'(issue_ready), 32'(m_ready()));
      clock_edge();
      check($sformatf("rand%0d pending", c), 32'(pending), 32'(m_pending()));
      check($sformatf("rand%0d idle", c), 32'(idle), 32'((m_pending() == 0) && !m_long));
      check($sformatf("rand%0d wb_err", c), 32'(wb_err), 32'(m_err));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
